// File: rtl/spi_ram.sv
// SPI slave-side RAM: decodes 10-bit command words (opcode + address/data)
// into address loads, memory writes and single-cycle-latency reads.
module spi_ram #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] din,
   input  logic       rx_valid,
   output logic [7:0] dout,
   output logic       tx_valid
);

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } op_e;

   op_e                  op;
   logic [7:0]           mem_q [MEM_DEPTH];
   logic                 mem_we;
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic [7:0]           dout_q, dout_d;
   logic                 tx_valid_q, tx_valid_d;

   assign op = op_e'(din[9:8]);

   // NOTE: every variable gets a default before the case, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      dout_d     = dout_q;
      tx_valid_d = 1'b0;
      mem_we     = 1'b0;
      if (rx_valid) begin
         unique case (op)
            OP_WR_ADDR: wr_addr_d = ADDR_SIZE'(din[7:0]);
            OP_WR_DATA: mem_we    = rst_n;
            OP_RD_ADDR: rd_addr_d = ADDR_SIZE'(din[7:0]);
            OP_RD_DATA: begin
               dout_d     = mem_q[rd_addr_q];
               tx_valid_d = 1'b1;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         dout_q     <= 8'h00;
         tx_valid_q <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   // NOTE: the array has no reset branch, so it maps onto plain RAM and keeps
   // its contents through reset; a write coinciding with reset is suppressed
   // through mem_we instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_addr_q] <= din[7:0];
      end
   end

   assign dout     = dout_q;
   assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram.sv
// Self-checking bench for spi_ram: directed scenarios plus randomized traffic,
// compared against an array-based command model.
module tb_spi_ram;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] din;
   logic       rx_valid;
   logic [7:0] dout;
   logic       tx_valid;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [7:0] m_mem [256];
   bit         m_known [256];
   logic [7:0] m_wa, m_ra, m_dout;
   bit         m_dout_known;
   logic       m_tx;

   spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .rx_valid (rx_valid),
      .dout     (dout),
      .tx_valid (tx_valid)
   );

   always #5 clk = ~clk;

   // Drives one cycle from a negedge, updates the model after the edge and
   // returns at the following negedge where outputs are sampled.
   task automatic step(input logic rst, input logic rxv, input logic [9:0] d);
      rst_n    = rst;
      rx_valid = rxv;
      din      = d;
      @(posedge clk);
      #1;
      if (!rst) begin
         m_wa = 8'h00; m_ra = 8'h00; m_dout = 8'h00; m_dout_known = 1; m_tx = 1'b0;
      end else if (rxv) begin
         m_tx = 1'b0;
         case (d[9:8])
            2'b00: m_wa = d[7:0];
            2'b01: begin m_mem[m_wa] = d[7:0]; m_known[m_wa] = 1; end
            2'b10: m_ra = d[7:0];
            default: begin
               m_dout = m_mem[m_ra]; m_dout_known = m_known[m_ra]; m_tx = 1'b1;
            end
         endcase
      end else begin
         m_tx = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic cmd(input logic [1:0] op, input logic [7:0] d);
      step(1'b1, 1'b1, {op, d});
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 10'($urandom));
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 10'h000);
      step(1'b0, 1'b1, 10'h3FF);
      n_tests++;
      if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
      n_tests++;
      if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx: got %b want 0", tx_valid); end
   endtask

   task automatic test_write_read();
      cmd(2'b00, 8'h12); cmd(2'b01, 8'hAB); cmd(2'b10, 8'h12); cmd(2'b11, 8'h5C);
      n_tests++;
      if (dout !== 8'hAB || tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL wr_rd: got dout=%h tx=%b want AB 1", dout, tx_valid);
      end
      idle();
      n_tests++;
      if (tx_valid !== 1'b0 || dout !== 8'hAB) begin
         n_fail++; $display("FAIL wr_rd_pulse: got dout=%h tx=%b want AB 0", dout, tx_valid);
      end
   endtask

   task automatic test_idle_gaps();
      logic [9:0] seq [4];
      seq = '{10'h012, 10'h1AB, 10'h212, 10'h300};
      cmd(2'b10, 8'h00); cmd(2'b11, 8'h00);   // move dout away from AB first
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
            idle();
            n_tests++;
            if (tx_valid !== 1'b0 || (m_dout_known && dout !== m_dout)) begin
               n_fail++; $display("FAIL gap_idle: got dout=%h tx=%b want %h 0", dout, tx_valid, m_dout);
            end
         end
         step(1'b1, 1'b1, seq[i]);
      end
      n_tests++;
      if (dout !== 8'hAB || tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL gap_result: got dout=%h tx=%b want AB 1", dout, tx_valid);
      end
   endtask

   task automatic test_hold();
      logic [9:0] seq [3];
      seq = '{10'h005, 10'h177, 10'h205};
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, seq[i]);
         n_tests++;
         if (dout !== 8'hAB || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_%0d: got dout=%h tx=%b want AB 0", i, dout, tx_valid);
         end
      end
      cmd(2'b11, 8'h00);
      n_tests++;
      if (dout !== 8'h77 || tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL hold_read: got dout=%h tx=%b want 77 1", dout, tx_valid);
      end
   endtask

   task automatic test_back_to_back();
      cmd(2'b00, 8'h00); cmd(2'b01, 8'h11); cmd(2'b00, 8'h01); cmd(2'b01, 8'h22);
      cmd(2'b10, 8'h00); cmd(2'b11, 8'h00);
      n_tests++;
      if (dout !== 8'h11 || tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL b2b_first: got dout=%h tx=%b want 11 1", dout, tx_valid);
      end
      cmd(2'b10, 8'h01);
      n_tests++;
      if (dout !== 8'h11 || tx_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_gap: got dout=%h tx=%b want 11 0", dout, tx_valid);
      end
      cmd(2'b11, 8'h00);
      n_tests++;
      if (dout !== 8'h22 || tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL b2b_second: got dout=%h tx=%b want 22 1", dout, tx_valid);
      end
      cmd(2'b10, 8'h00);
      for (int i = 0; i < 2; i++) begin
         cmd(2'b11, 8'h00);
         n_tests++;
         if (dout !== 8'h11 || tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_adjacent_%0d: got dout=%h tx=%b want 11 1", i, dout, tx_valid);
         end
      end
      // Write immediately followed by a read of the same address
      cmd(2'b00, 8'h40); cmd(2'b10, 8'h40); cmd(2'b01, 8'h5A); cmd(2'b11, 8'h00);
      n_tests++;
      if (dout !== 8'h5A || tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL wr_then_rd: got dout=%h tx=%b want 5A 1", dout, tx_valid);
      end
   endtask

   task automatic test_reset_mid();
      cmd(2'b00, 8'h12);
      step(1'b0, 1'b1, 10'h199);
      n_tests++;
      if (dout !== 8'h00 || tx_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid: got dout=%h tx=%b want 00 0", dout, tx_valid);
      end
      cmd(2'b11, 8'h00);   // rd_addr back to 0 after reset
      n_tests++;
      if (dout !== 8'h11 || tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL rst_rd_addr0: got dout=%h tx=%b want 11 1", dout, tx_valid);
      end
      cmd(2'b01, 8'h3C); cmd(2'b11, 8'h00);   // wr_addr back to 0 after reset
      n_tests++;
      if (dout !== 8'h3C) begin n_fail++; $display("FAIL rst_wr_addr0: got %h want 3C", dout); end
      cmd(2'b10, 8'h12); cmd(2'b11, 8'h00);
      n_tests++;
      if (dout !== 8'hAB) begin n_fail++; $display("FAIL rst_write_dropped: got %h want AB", dout); end
   endtask

   task automatic test_boundary();
      cmd(2'b00, 8'hFF); cmd(2'b01, 8'hFF); cmd(2'b00, 8'h00); cmd(2'b01, 8'h01);
      cmd(2'b10, 8'hFF); cmd(2'b11, 8'h00);
      n_tests++;
      if (dout !== 8'hFF || tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL bound_ff: got dout=%h tx=%b want FF 1", dout, tx_valid);
      end
      cmd(2'b10, 8'h00); cmd(2'b11, 8'h00);
      n_tests++;
      if (dout !== 8'h01 || tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL bound_00: got dout=%h tx=%b want 01 1", dout, tx_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic       rst, rxv;
         logic [9:0] d;
         rst = ($urandom_range(0, 59) != 0);
         rxv = ($urandom_range(0, 3) != 0);
         d   = 10'($urandom);
         if ($urandom_range(0, 1) == 1) d[7:0] = 8'($urandom_range(0, 7));  // reuse addresses
         step(rst, rxv, d);
         n_tests++;
         if (tx_valid !== m_tx || (m_dout_known && dout !== m_dout)) begin
            n_fail++;
            $display("FAIL random_%0d: got dout=%h tx=%b want %h %b", i, dout, tx_valid, m_dout, m_tx);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) m_known[i] = 0;
      m_dout_known = 0;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      din      = 10'h000;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_idle_gaps();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      test_boundary();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 Parameter MEM_DEPTH, default 256, SHALL set the number of memory words.
REQ-002 Parameter ADDR_SIZE, default 8, SHALL set the address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: synchronous and active-low.
REQ-005 Port din  input  10  SHALL carry the command word from the SPI slave: din[9:8] is the opcode and din[7:0] is the address or data.
REQ-006 Port rx_valid  input  1  SHALL qualify din; a command is accepted only on a rising edge where rx_valid=1.
REQ-007 Port dout  output  8  SHALL carry the read data returned to the SPI slave (tx_data).
REQ-008 Port tx_valid  output  1  SHALL qualify dout toward the SPI slave.

Function
REQ-009 The block SHALL hold a MEM_DEPTH x 8 single-port array plus registered write address wr_addr and read address rd_addr, each ADDR_SIZE bits wide.
REQ-010 Opcode 2'b00 (write address) SHALL load wr_addr <= din[7:0]; dout and tx_valid SHALL be unchanged apart from REQ-014.
REQ-011 Opcode 2'b01 (write data) SHALL perform mem[wr_addr] <= din[7:0] in the accept cycle; wr_addr SHALL be unchanged.
REQ-012 Opcode 2'b10 (read address) SHALL load rd_addr <= din[7:0].
REQ-013 Opcode 2'b11 (read data) SHALL register dout <= mem[rd_addr] and set tx_valid=1, both visible one cycle after the accept edge (latency 1); rd_addr SHALL be unchanged.
REQ-014 tx_valid SHALL be a single-cycle pulse: it is 1 only in the cycle following an accepted 2'b11 and 0 otherwise.
REQ-015 Back-to-back 2'b11 commands SHALL produce tx_valid=1 in consecutive cycles, each with freshly read dout.
REQ-016 dout SHALL hold its last value until the next accepted 2'b11 or a reset; it SHALL NOT change on opcodes 00, 01 or 10.
REQ-017 With rx_valid=0, din SHALL be ignored: no register or memory changes, and tx_valid SHALL be 0.
REQ-018 A 2'b01 to address A followed by a 2'b11 with rd_addr=A in the very next cycle SHALL return the newly written value (write-before-read ordering).
REQ-019 Addresses SHALL use the full ADDR_SIZE range 0..MEM_DEPTH-1 with no wrap or saturation logic; no address auto-increments.
REQ-020 A 2'b01 or 2'b11 issued without a preceding address command since reset SHALL use address 0.
REQ-021 Memory contents SHALL NOT be initialised by reset; a read of a never-written location is undefined and SHALL NOT be checked.

Reset
REQ-022 On a rising edge with rst_n=0, the block SHALL set wr_addr=0, rd_addr=0, dout=8'h00 and tx_valid=0, regardless of rx_valid or din.
REQ-023 Reset SHALL take priority over any command in the same cycle; that command SHALL be dropped, including a 2'b01 write (memory is not modified).
REQ-024 Memory contents written before a reset SHALL be preserved through it.

Verification
REQ-025 Write/read: 00_0x12, 01_0xAB, 10_0x12, 11_xx -> the cycle after the 11 accept shows dout=0xAB and tx_valid=1 for exactly one cycle.
REQ-026 Idle gaps: the same sequence with rx_valid=0 cycles and random din between commands -> identical result, and tx_valid=0 during every gap.
REQ-027 Hold: after REQ-025, issue 00_0x05, 01_0x77, 10_0x05 -> dout stays 0xAB throughout; a following 11 gives dout=0x77.
REQ-028 Back-to-back: write 0x11@0x00 and 0x22@0x01; then 10_0x00, 11, 10_0x01, 11 -> tx_valid pulses carry 0x11 then 0x22; with two consecutive 11s on 0x00 -> two adjacent pulses, both 0x11.
REQ-029 Reset mid-operation: assert rst_n=0 in the same cycle as 01_0x99 to wr_addr 0x12 -> dout=0x00, tx_valid=0, the write is dropped, and a later read of 0x12 returns 0xAB.
REQ-030 Boundary: write 0xFF@0xFF and 0x01@0x00, then read both -> 0xFF and 0x01 returned, with no aliasing between them.
